// File: rtl/k_alu_arith_core.sv
// Registered K-ALU arithmetic stage: one shared 33-bit adder covers ADD/SUB/INC/DEC,
// alongside an op-independent signed compare. All outputs come straight from flops.
module k_alu_arith_core #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] slt,
  output logic [WIDTH-1:0] sgt
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf_c;
  logic             lt_c, gt_c;

  // Subtraction is X + ~Y + 1, so SUB and DEC reuse the same adder with an inverted operand.
  always_comb begin
    y   = b;
    cin = 1'b0;
    unique case (op)
      OP_ADD: begin y = b;       cin = 1'b0; end
      OP_SUB: begin y = ~b;      cin = 1'b1; end
      OP_INC: begin y = STEP_V;  cin = 1'b0; end
      OP_DEC: begin y = ~STEP_V; cin = 1'b1; end
    endcase
    sum   = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    ovf_c = (a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lt_c  = $signed(a) < $signed(b);
    gt_c  = $signed(a) > $signed(b);
  end

  logic lt_q, gt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res  <= sum[WIDTH-1:0];
        cout <= sum[WIDTH];
        ovf  <= ovf_c;
        zero <= (sum[WIDTH-1:0] == '0);
        lt_q <= lt_c;
        gt_q <= gt_c;
      end
    end
  end

  assign slt = {{(WIDTH-1){1'b0}}, lt_q};
  assign sgt = {{(WIDTH-1){1'b0}}, gt_q};

endmodule

// File: tb/tb_k_alu_arith_core.sv
// Directed-vector bench for k_alu_arith_core: table of hand-computed results plus
// reset, back-to-back and hold sequences.
module tb_k_alu_arith_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [1:0]  op = 2'b00;
  logic        out_valid, cout, ovf, zero;
  logic [31:0] res, slt, sgt;

  k_alu_arith_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .res(res), .cout(cout), .ovf(ovf), .zero(zero),
    .slt(slt), .sgt(sgt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic        cout, ovf, zero, lt, gt;
  } vec_t;

  vec_t tbl[12];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic [1:0] o, logic [31:0] xa, logic [31:0] xb, logic [31:0] r,
                              logic c, logic v, logic z, logic l, logic g);
    vec_t t;
    t.op = o; t.a = xa; t.b = xb; t.res = r;
    t.cout = c; t.ovf = v; t.zero = z; t.lt = l; t.gt = g;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_vec(string tag, vec_t t, logic vld);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, vld});
    chk({tag, ".res"},  res, t.res);
    chk({tag, ".cout"}, {31'b0, cout}, {31'b0, t.cout});
    chk({tag, ".ovf"},  {31'b0, ovf},  {31'b0, t.ovf});
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, t.zero});
    chk({tag, ".slt"},  slt, {31'b0, t.lt});
    chk({tag, ".sgt"},  sgt, {31'b0, t.gt});
  endtask

  task automatic drive(vec_t t);
    in_valid = 1'b1; op = t.op; a = t.a; b = t.b;
  endtask

  vec_t zv;

  initial begin
    //              op     a             b             res           c  v  z  lt gt
    tbl[0]  = mk(2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 1, 0);
    tbl[1]  = mk(2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 0, 1);
    tbl[2]  = mk(2'b01, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 0, 1, 0);
    tbl[3]  = mk(2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 0, 1, 0);
    tbl[4]  = mk(2'b10, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 1, 0, 1, 1, 0);
    tbl[5]  = mk(2'b11, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 0, 0, 0, 0, 1);
    tbl[6]  = mk(2'b11, 32'h00000004, 32'h00000000, 32'h00000000, 1, 0, 1, 0, 1);
    tbl[7]  = mk(2'b00, 32'h00001234, 32'h00001234, 32'h00002468, 0, 0, 0, 0, 0);
    tbl[8]  = mk(2'b01, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 0, 1, 0, 0, 1);
    tbl[9]  = mk(2'b00, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1, 0, 0);
    tbl[10] = mk(2'b10, 32'h7FFFFFFC, 32'h00000005, 32'h80000000, 0, 1, 0, 0, 1);
    tbl[11] = mk(2'b01, 32'h00000003, 32'h00000003, 32'h00000000, 1, 0, 1, 0, 0);
    zv = mk(2'b00, '0, '0, '0, 0, 0, 0, 0, 0);

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 chk_vec("por", zv, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Isolated vectors: one op, then an idle edge
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) drive(tbl[i]);
      @(negedge clk) begin
        n_vec++;
        chk_vec($sformatf("vec%0d", i), tbl[i], 1'b1);
        in_valid = 1'b0;
      end
    end

    // Back-to-back: 4 ops in consecutive cycles, results one per cycle in order
    @(negedge clk) drive(tbl[0]);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk) begin
        n_vec++;
        chk_vec($sformatf("b2b%0d", i - 1), tbl[i - 1], 1'b1);
        drive(tbl[i]);
      end
    end
    @(negedge clk) begin
      n_vec++;
      chk_vec("b2b3", tbl[3], 1'b1);
      in_valid = 1'b0;
      a = 32'hDEADBEEF; b = 32'h1;
    end
    // Hold: outputs keep the last result, out_valid low
    for (int i = 0; i < 2; i++)
      @(negedge clk) chk_vec($sformatf("hold%0d", i), tbl[3], 1'b0);

    // Mid-stream reset with in_valid high: outputs clear immediately
    @(negedge clk) drive(tbl[1]);
    @(posedge clk) #2 rst_n = 1'b0;
    #1 chk_vec("rst_mid", zv, 1'b0);
    @(negedge clk) begin
      chk_vec("rst_hold", zv, 1'b0);
      rst_n = 1'b1;
      drive(tbl[8]);
    end
    #1 chk_vec("rst_rel", zv, 1'b0);
    @(negedge clk) begin
      n_vec++;
      chk_vec("rst_first", tbl[8], 1'b1);
      in_valid = 1'b0;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
